// File: rtl/shifter.sv
// Partial-product aligner: places an 8-bit product at bit offset 0, 4 or 8 of a 16-bit word.
// Define SHIFTER_OUT_REG_EN to add a 16-bit output register (one cycle latency, async clear).
module shifter (
    input  logic        clk,
    input  logic        reset_a,
    input  logic [7:0]  inp,
    input  logic [1:0]  shift_cntrl,
    output logic [15:0] shift_out
);

    logic [15:0] shift_d;

    always_comb begin
        shift_d = {8'h00, inp};
        case (shift_cntrl)
            2'b01:   shift_d = {4'h0, inp, 4'h0};
            2'b10:   shift_d = {inp, 8'h00};
            // 2'b11 is reserved and aliases to no shift, as does any unknown code.
            default: shift_d = {8'h00, inp};
        endcase
    end

`ifdef SHIFTER_OUT_REG_EN
    logic [15:0] shift_q;

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            shift_q <= 16'h0000;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign shift_out = shift_q;
`else
    // Clock and reset are kept on the port list so both builds are pin-compatible.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, reset_a};

    assign shift_out = shift_d;
`endif

endmodule

// File: tb/tb_shifter.sv
// Self-checking bench for shifter; works for both the combinational and the
// SHIFTER_OUT_REG_EN registered build.
module tb_shifter;

    logic        clk;
    logic        reset_a;
    logic [7:0]  inp;
    logic [1:0]  shift_cntrl;
    logic [15:0] shift_out;

    int n_checks;
    int n_fail;
    logic [15:0] exp_q[$];

    shifter dut (
        .clk         (clk),
        .reset_a     (reset_a),
        .inp         (inp),
        .shift_cntrl (shift_cntrl),
        .shift_out   (shift_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: multiply by the power of two selected by the code
    function automatic logic [15:0] ref_align(input logic [7:0] a, input logic [1:0] c);
        int unsigned v;
        v = a;
        if (c == 2'd1)
            v = v * 16;
        else if (c == 2'd2)
            v = v * 256;
        return v[15:0];
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver: apply at negedge, sample once the result is due
    task automatic apply(input string tag, input logic [7:0] a, input logic [1:0] c);
        logic [15:0] exp;
        @(negedge clk);
        inp = a;
        shift_cntrl = c;
        exp_q.push_back(ref_align(a, c));
`ifdef SHIFTER_OUT_REG_EN
        @(posedge clk);
`endif
        #1;
        exp = exp_q.pop_front();
        check(tag, shift_out, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset_a = 1'b1;
        inp = 8'h00;
        shift_cntrl = 2'd0;
        #3;
`ifdef SHIFTER_OUT_REG_EN
        check("reset_clear", shift_out, 16'h0000);
        inp = 8'hFF;
        shift_cntrl = 2'd2;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", shift_out, 16'h0000);
`else
        check("reset_comb", shift_out, 16'h0000);
`endif
        @(negedge clk);
        reset_a = 1'b0;

        // directed vectors
        apply("d100_c0", 8'd100, 2'd0);
        apply("d100_c3", 8'd100, 2'd3);
        apply("d100_c1", 8'd100, 2'd1);
        apply("d100_c2", 8'd100, 2'd2);
        apply("d18_c3", 8'd18, 2'd3);
        apply("d18_c1", 8'd18, 2'd1);
        apply("d18_c2", 8'd18, 2'd2);
        for (int c = 0; c < 4; c++) apply("ff_sweep", 8'hFF, 2'(c));
        for (int c = 0; c < 4; c++) apply("zero_sweep", 8'h00, 2'(c));

        // spot-check literal values independently of the model
        apply("lit_6400", 8'd100, 2'd2);
        check("lit_6400_const", shift_out, 16'h6400);

`ifdef SHIFTER_OUT_REG_EN
        // asynchronous reset mid-cycle, then first edge after release
        #2;
        reset_a = 1'b1;
        #1;
        check("async_reset", shift_out, 16'h0000);
        @(negedge clk);
        inp = 8'd18;
        shift_cntrl = 2'd1;
        #1;
        reset_a = 1'b0;
        #1;
        check("no_load_before_edge", shift_out, 16'h0000);
        @(posedge clk);
        #1;
        check("first_edge_load", shift_out, 16'h0120);
        // input change between edges stays invisible until the edge
        @(negedge clk);
        inp = 8'hFF;
        shift_cntrl = 2'd2;
        #1;
        check("hold_between_edges", shift_out, 16'h0120);
        @(posedge clk);
        #1;
        check("update_at_edge", shift_out, 16'hFF00);
`else
        // zero-latency: output follows input without any clock edge
        @(posedge clk);
        #1;
        inp = 8'hA5;
        shift_cntrl = 2'd1;
        #1;
        check("comb_follow", shift_out, 16'h0A50);
`endif

        // randomized stimulus
        for (int i = 0; i < 200; i++) begin
            apply("random", 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
